fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares one async_fifo write side between NUM_REQ requesters, each with a valid/ready/last stream.
- Grants one requester at a time for a burst: until its last beat or MAX_BURST beats, whichever comes first.
- Drives registered wr_en/din into the FIFO and never writes when the FIFO is full.
- Lives entirely in the FIFO write-clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 64, beat width; equals the FIFO INPUT_WIDTH
MAX_BURST, 16, maximum beats per grant (1..256)

Ports:
wr_clock  in  1  write-side clock (same clock as the FIFO wr_clock)
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester beat valid
req_data  in  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_last  in  NUM_REQ  marks the last beat of a requester's packet
req_ready  out  NUM_REQ  per-requester accept; combinational
fifo_wr_en  out  1  FIFO write enable; registered
fifo_din  out  DATA_WIDTH  FIFO write data; registered
fifo_full  in  1  FIFO full
fifo_almost_full  in  1  FIFO has exactly one free slot
grant_id  out  $clog2(NUM_REQ)  currently granted requester
busy  out  1  high while in BURST

Behaviour:
- Reset (async assert, released synchronously to wr_clock):
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0.
  - fifo_wr_en=0, fifo_din=0, busy=0, req_ready=0.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_valid is high, pick the first requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - Register the winner into grant_id, clear beat_cnt, go to BURST.
  - req_ready stays all-zero in IDLE, so there is a 1-cycle arbitration bubble.
- Write-allowed flag: wr_ok = !fifo_full && !(fifo_wr_en && fifo_almost_full). This accounts for the write already in flight in the output register.
- BURST:
  - req_ready[grant_id] = wr_ok; all other req_ready bits are 0.
  - Accept occurs when req_valid[g] && req_ready[g]. On accept:
    - fifo_wr_en<=1 and fifo_din<=that requester's beat on the next edge (1-cycle latency);
    - beat_cnt++.
  - If there is no accept, fifo_wr_en<=0 on the next edge.
- Burst end: an accept with req_last[g]=1, or an accept with beat_cnt==MAX_BURST-1.
  - On burst end: go to IDLE and set rr_ptr <= (g+1) mod NUM_REQ.
- Grant hold: if the granted requester drops valid mid-burst, the grant is held indefinitely. There is no preemption.
- busy = (state==BURST).
- FIFO backpressure: while wr_ok=0, no beat is accepted and the burst simply stalls. No data is lost or duplicated.
- Ordering: beats from one requester reach the FIFO in acceptance order. Beats from different bursts never interleave.
- MAX_BURST=1: every accepted beat ends the burst, giving per-beat round-robin.
- Reset mid-burst: the burst is abandoned and an in-flight fifo_wr_en is dropped. Requesters must re-send the partial packet.

Optional Feature:
Macro FIFO_WR_ARB_STATS_EN.
- Defined:
  - Adds input stats_clr (1 bit) and output beat_count (NUM_REQ*32).
  - beat_count holds per-requester 32-bit counters of accepted beats.
  - Counters wrap at 2^32 and are reset to 0 by reset or by stats_clr.
  - If stats_clr and an accept happen in the same cycle, the counter becomes 0; clear wins.
- Not defined: the ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg holds:
  - arb_state_t enum {IDLE, BURST};
  - the width functions for the grant and beat counters ($clog2(NUM_REQ), $clog2(MAX_BURST)).
- Sub-module rr_pick: combinational rotating-priority picker.
  - Inputs: req vector and ptr.
  - Outputs: onehot, index, any.
  - Instantiated once in IDLE.

Test Plan:
1. NUM_REQ=4, MAX_BURST=16, all four requesters valid with 3-beat packets, FIFO never full -> grants in order 0,1,2,3,0; 3 FIFO writes per grant with a 1-cycle gap between grants; fifo_din matches each packet exactly.
2. Requester 2 streams 40 beats with last only on beat 40 -> grant released after beats 16, 32 and 40; requester 3 (valid) is granted between them.
3. fifo_almost_full=1 with a write in flight, then fifo_full=1 for 5 cycles -> req_ready=0 for those cycles; no fifo_wr_en while full; the scoreboard shows no lost or duplicated beat.
4. MAX_BURST=1, requesters 0 and 1 always valid -> fifo_din alternates between requester 0 and 1 beats, with a bubble between each.
5. Reset asserted mid-burst at beat 5 of 10 -> fifo_wr_en=0 and busy=0 immediately; after release, grant restarts at requester 0 (rr_ptr=0).
6. FIFO_WR_ARB_STATS_EN defined, 100 random beats, stats_clr pulsed at beat 50 -> beat_count sums to the number of beats accepted after the clear cycle; each per-requester counter matches the scoreboard.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } arb_state_t;

    // Grant index width; never narrower than one bit.
    function automatic int unsigned grant_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Beat counter width, counting 0 .. max_burst-1; never narrower than one bit.
    function automatic int unsigned beat_width(input int unsigned max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker. Returns the first set request
// at or after ptr_i, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0]   index_o,
    output logic               any_o
);

    logic [31:0] idx;

    // Scan from the pointer upward and keep the first hit.
    always_comb begin
        onehot_o = '0;
        index_o  = '0;
        any_o    = 1'b0;
        idx      = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (32'(ptr_i) + off) % NUM_REQ;
            if (!any_o && req_i[idx]) begin
                any_o         = 1'b1;
                index_o       = IDX_W'(idx);
                onehot_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port between
// NUM_REQ valid/ready/last streams. Writes are registered one cycle after accept.
// Optional per-requester accepted-beat counters: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned  NUM_REQ    = 4,
    parameter int unsigned  DATA_WIDTH = 64,
    parameter int unsigned  MAX_BURST  = 16,
    localparam int unsigned GntW       = grant_width(NUM_REQ)
) (
    input  logic                          wr_clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic [GntW-1:0]               grant_id,
    output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    input  logic                          stats_clr,
    output logic [NUM_REQ*32-1:0]         beat_count
`endif
);

    localparam int unsigned     CntW     = beat_width(MAX_BURST);
    localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BURST - 1);

    arb_state_t            state_q, state_d;
    logic [GntW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [GntW-1:0]       grant_q, grant_d;
    logic [NUM_REQ-1:0]    gnt_oh_q, gnt_oh_d;
    logic [CntW-1:0]       beat_cnt_q, beat_cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    logic [NUM_REQ-1:0]    pick_onehot;
    logic [GntW-1:0]       pick_index;
    logic                  pick_any;
    logic                  wr_ok;
    logic                  accept;
    logic                  gnt_last;
    logic                  burst_end;
    logic [DATA_WIDTH-1:0] gnt_data;

    rr_pick #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (GntW)
    ) u_rr_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .onehot_o(pick_onehot),
        .index_o (pick_index),
        .any_o   (pick_any)
    );

    // A write already in the output register consumes the last free slot.
    assign wr_ok     = !fifo_full && !(wr_en_q && fifo_almost_full);
    assign req_ready = (state_q == StBurst) ? (gnt_oh_q & {NUM_REQ{wr_ok}}) : '0;
    assign accept    = |(req_valid & req_ready);
    assign gnt_last  = |(req_last & gnt_oh_q);
    assign burst_end = accept && (gnt_last || (beat_cnt_q == LastBeat));

    // Select the granted requester's beat with a one-hot AND-OR mux.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh_q[i]) begin
                gnt_data = gnt_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state: arbitrate in idle, stream beats in burst until last or MAX_BURST.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        gnt_oh_d   = gnt_oh_q;
        beat_cnt_d = beat_cnt_q;
        wr_en_d    = 1'b0;
        din_d      = din_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    grant_d    = pick_index;
                    gnt_oh_d   = pick_onehot;
                    beat_cnt_d = '0;
                    state_d    = StBurst;
                end
            end
            StBurst: begin
                if (accept) begin
                    wr_en_d    = 1'b1;
                    din_d      = gnt_data;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (burst_end) begin
                        state_d  = StIdle;
                        rr_ptr_d = (grant_q == GntW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset drops any in-flight write.
    always_ff @(posedge wr_clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            gnt_oh_q   <= '0;
            beat_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            gnt_oh_q   <= gnt_oh_d;
            beat_cnt_q <= beat_cnt_d;
            wr_en_q    <= wr_en_d;
            din_q      <= din_d;
        end
    end

    assign fifo_wr_en = wr_en_q;
    assign fifo_din   = din_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q == StBurst);

`ifdef FIFO_WR_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] stat_q;

    // Per-requester accepted-beat counters; clear wins over a same-cycle accept.
    always_ff @(posedge wr_clock or posedge reset) begin
        if (reset) begin
            stat_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stats_clr) begin
                    stat_q[i] <= '0;
                end else if (req_valid[i] && req_ready[i]) begin
                    stat_q[i] <= stat_q[i] + 32'd1;
                end
            end
        end
    end

    assign beat_count = stat_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench. Requesters are modelled as beat queues;
// every FIFO write is captured with its cycle stamp and compared to hand-built
// expected sequences. A second instance with MAX_BURST=1 covers per-beat RR.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 64;

    logic wr_clock = 1'b0;
    logic reset;
    always #5 wr_clock = ~wr_clock;

    logic [NR-1:0]    req_valid, req_last, req_ready;
    logic [NR*DW-1:0] req_data;
    logic             fifo_full, fifo_almost_full, fifo_wr_en, busy;
    logic [DW-1:0]    fifo_din;
    logic [1:0]       grant_id;

    logic [NR-1:0]    v2, l2, r2;
    logic [NR*DW-1:0] d2;
    logic             we2, busy2;
    logic [DW-1:0]    din2;
    logic [1:0]       gid2;

`ifdef FIFO_WR_ARB_STATS_EN
    logic             stats_clr;
    logic [NR*32-1:0] beat_count, beat_count2;
    logic             nxt_clr, clr_prev;
    int unsigned      model_cnt [NR];
`endif

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(16)) dut (
        .wr_clock        (wr_clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_din        (fifo_din),
        .fifo_full       (fifo_full),
        .fifo_almost_full(fifo_almost_full),
        .grant_id        (grant_id),
        .busy            (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stats_clr       (stats_clr),
        .beat_count      (beat_count)
`endif
    );

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(1)) dut1 (
        .wr_clock        (wr_clock),
        .reset           (reset),
        .req_valid       (v2),
        .req_data        (d2),
        .req_last        (l2),
        .req_ready       (r2),
        .fifo_wr_en      (we2),
        .fifo_din        (din2),
        .fifo_full       (fifo_full),
        .fifo_almost_full(fifo_almost_full),
        .grant_id        (gid2),
        .busy            (busy2)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stats_clr       (stats_clr),
        .beat_count      (beat_count2)
`endif
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int id, input int n);
        return {32'(id), 32'(n)};
    endfunction

    // Requester beat queues and the accept masks seen just before each edge.
    logic [DW-1:0] qd [NR][$];
    logic          ql [NR][$];
    logic [NR-1:0] acc_mask, acc2_mask;
    int            pop_cnt [NR];
    int            seq2 [2];
    logic          en2, nxt_full, nxt_af;

    // Captured FIFO writes with negedge cycle stamps.
    int            cyc = 0;
    logic [DW-1:0] got[$], got2[$];
    int            stamp[$], stamp2[$];

    initial forever begin
        @(negedge wr_clock);
        cyc++;
        if (fifo_wr_en) begin
            got.push_back(fifo_din);
            stamp.push_back(cyc);
        end
        if (we2) begin
            got2.push_back(din2);
            stamp2.push_back(cyc);
        end
    end

    // One cycle: retire beats accepted at the last edge, drive new inputs, then
    // note which beats the coming edge will accept.
    task automatic step();
        @(negedge wr_clock);
`ifdef FIFO_WR_ARB_STATS_EN
        for (int i = 0; i < NR; i++) begin
            if (clr_prev) model_cnt[i] = 0;
            else if (acc_mask[i]) model_cnt[i]++;
        end
        stats_clr = nxt_clr;
`endif
        for (int i = 0; i < NR; i++) begin
            if (acc_mask[i]) begin
                void'(qd[i].pop_front());
                void'(ql[i].pop_front());
                pop_cnt[i]++;
            end
        end
        for (int i = 0; i < 2; i++) if (acc2_mask[i]) seq2[i]++;
        fifo_full        = nxt_full;
        fifo_almost_full = nxt_af;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]           = (qd[i].size() != 0);
            req_data[i*DW +: DW]   = req_valid[i] ? qd[i][0] : '0;
            req_last[i]            = req_valid[i] ? ql[i][0] : 1'b0;
            d2[i*DW +: DW]         = (i < 2) ? mk(i + 256, seq2[i % 2]) : '0;
        end
        v2 = en2 ? 4'b0011 : 4'b0000;
        l2 = 4'b1111;
        #1;
        acc_mask  = req_valid & req_ready;
        acc2_mask = v2 & r2;
`ifdef FIFO_WR_ARB_STATS_EN
        clr_prev = stats_clr;
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NR; i++) begin
            qd[i].delete();
            ql[i].delete();
            pop_cnt[i] = 0;
        end
        acc_mask = '0; acc2_mask = '0; en2 = 1'b0; nxt_full = 1'b0; nxt_af = 1'b0;
        seq2[0] = 0; seq2[1] = 0;
`ifdef FIFO_WR_ARB_STATS_EN
        nxt_clr = 1'b0; clr_prev = 1'b0;
        for (int i = 0; i < NR; i++) model_cnt[i] = 0;
`endif
        step();
        step();
        reset = 1'b0;
        got.delete(); stamp.delete(); got2.delete(); stamp2.delete();
    endtask

    task automatic load(input int id, input int n0, input int len, input bit last_end);
        for (int n = 0; n < len; n++) begin
            qd[id].push_back(mk(id, n0 + n));
            ql[id].push_back(last_end && (n == len - 1));
        end
    endtask

    task automatic run_until(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (got.size() < n && k < budget) begin
            step();
            k++;
        end
        check(tag, 64'(got.size()), 64'(n));
    endtask

    logic [63:0] exp_q[$];

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};
        reset = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0;
        v2 = '0; l2 = '0; d2 = '0;
        fifo_full = 1'b0; fifo_almost_full = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        do_reset();

        // Reset state
        check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst_din", fifo_din, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);

        // 1: four requesters, 3-beat packets; requester 0 has two packets
        load(0, 0, 3, 1'b1); load(0, 3, 3, 1'b1);
        load(1, 0, 3, 1'b1); load(2, 0, 3, 1'b1); load(3, 0, 3, 1'b1);
        run_until("t1_count", 15, 200);
        for (int k = 0; k < got.size() && k < 15; k++) begin
            check($sformatf("t1_din%0d", k), got[k],
                  mk(order[k/3], (k >= 12) ? 3 + k % 3 : k % 3));
            if (k > 0) check($sformatf("t1_gap%0d", k), 64'(stamp[k] - stamp[k-1]),
                             (k % 3 == 0) ? 64'd2 : 64'd1);
        end
        repeat (4) step();
        check("t1_no_extra", 64'(got.size()), 64'd15);

        // 2: long packet on requester 2 split at MAX_BURST, requester 3 interleaved
        do_reset();
        load(2, 0, 40, 1'b1);
        load(3, 0, 2, 1'b1); load(3, 2, 2, 1'b1);
        exp_q.delete();
        for (int n = 0; n < 16; n++) exp_q.push_back(mk(2, n));
        exp_q.push_back(mk(3, 0)); exp_q.push_back(mk(3, 1));
        for (int n = 16; n < 32; n++) exp_q.push_back(mk(2, n));
        exp_q.push_back(mk(3, 2)); exp_q.push_back(mk(3, 3));
        for (int n = 32; n < 40; n++) exp_q.push_back(mk(2, n));
        run_until("t2_count", 44, 300);
        for (int k = 0; k < got.size() && k < 44; k++)
            check($sformatf("t2_din%0d", k), got[k], exp_q[k]);

        // 3: almost_full with a write in flight, then full for 5 cycles
        do_reset();
        load(1, 0, 8, 1'b1);
        step();
        step();
        check("t3_grant", 64'(grant_id), 64'd1);
        check("t3_ready_ok", 64'(req_ready), 64'b0010);
        nxt_af = 1'b1;
        step();
        check("t3_inflight", 64'(fifo_wr_en), 64'd1);
        check("t3_ready_af", 64'(req_ready), 64'd0);
        nxt_af = 1'b0; nxt_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("t3_ready_full%0d", c), 64'(req_ready), 64'd0);
            check($sformatf("t3_wr_full%0d", c), 64'(fifo_wr_en), 64'd0);
        end
        check("t3_busy", 64'(busy), 64'd1);
        nxt_full = 1'b0;
        run_until("t3_count", 8, 100);
        for (int k = 0; k < got.size() && k < 8; k++)
            check($sformatf("t3_din%0d", k), got[k], mk(1, k));

        // 4: MAX_BURST=1 instance, requesters 0 and 1 always valid
        do_reset();
        en2 = 1'b1;
        for (int c = 0; c < 40 && got2.size() < 6; c++) step();
        check("t4_count", 64'(got2.size() >= 6), 64'd1);
        for (int k = 0; k < got2.size() && k < 6; k++) begin
            check($sformatf("t4_din%0d", k), got2[k], mk(256 + k % 2, k / 2));
            if (k > 0) check($sformatf("t4_gap%0d", k), 64'(stamp2[k] - stamp2[k-1]), 64'd2);
        end
        en2 = 1'b0;

        // 5: reset in the middle of a 10-beat packet
        do_reset();
        load(2, 0, 10, 1'b1);
        for (int c = 0; c < 50 && pop_cnt[2] < 5; c++) step();
        check("t5_pre_wr", 64'(fifo_wr_en), 64'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_wr", 64'(fifo_wr_en), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        do_reset();
        load(2, 0, 3, 1'b1);
        load(0, 0, 3, 1'b1);
        step();
        step();
        check("t5_grant", 64'(grant_id), 64'd0);
        run_until("t5_count", 6, 100);
        for (int k = 0; k < got.size() && k < 6; k++)
            check($sformatf("t5_din%0d", k), got[k], mk(k < 3 ? 0 : 2, k % 3));

`ifdef FIFO_WR_ARB_STATS_EN
        // 6: 100 random beats, counters cleared once around beat 50
        begin
            int tot;
            int sum;
            do_reset();
            for (int b = 0; b < 100; b++) begin
                int id;
                id = int'($urandom_range(0, NR - 1));
                qd[id].push_back(mk(id, b));
                ql[id].push_back($urandom_range(0, 3) == 0);
            end
            for (int i = 0; i < NR; i++) if (ql[i].size() != 0) ql[i][ql[i].size() - 1] = 1'b1;
            tot = 0;
            for (int c = 0; c < 1000 && got.size() < 100; c++) begin
                nxt_clr = (tot >= 50 && tot < 52 && nxt_clr == 1'b0 && c > 0) ? 1'b1 : 1'b0;
                if (tot >= 52) nxt_clr = 1'b0;
                step();
                tot = pop_cnt[0] + pop_cnt[1] + pop_cnt[2] + pop_cnt[3];
            end
            nxt_clr = 1'b0;
            step();
            step();
            check("t6_count", 64'(got.size()), 64'd100);
            sum = 0;
            for (int i = 0; i < NR; i++) begin
                check($sformatf("t6_cnt%0d", i), 64'(beat_count[i*32 +: 32]), 64'(model_cnt[i]));
                sum += int'(beat_count[i*32 +: 32]);
            end
            check("t6_sum", 64'(sum),
                  64'(model_cnt[0] + model_cnt[1] + model_cnt[2] + model_cnt[3]));
        end
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
